// File: rtl/neo_d0_sys_if.sv
// ============================================================================
// neo_d0_sys_if : Z80 bus, 68k sound-command strobe and decoded outputs of NEO-D0
// Rev 1.0
// ============================================================================
`default_nettype none

interface neo_d0_sys_if;
    // Z80 / 68k side
    logic [4:0] SDA_H;
    logic [2:0] SDA_L;
    logic       nSDRD;
    logic       nSDWR;
    logic       nMREQ;
    logic       nIORQ;
    logic       nSDW;

    // Divided clocks
    logic       CLK_12M;
    logic       CLK_68KCLK;
    logic       CLK_68KCLKB;
    logic       CLK_6MB;
    logic       CLK_1MB;

    // NMI and decoded strobes
    logic       nZ80NMI;
    logic       nSDZ80R;
    logic       nSDZ80W;
    logic       nSDZ80CLR;
    logic       nSDROM;
    logic       nSDMRD;
    logic       nSDMWR;
    logic       SDRD0;
    logic       SDRD1;
    logic       n2610CS;
    logic       n2610RD;
    logic       n2610WR;
    logic       nZRAMCS;

    modport master (
        output SDA_H, SDA_L, nSDRD, nSDWR, nMREQ, nIORQ, nSDW,
        input  CLK_12M, CLK_68KCLK, CLK_68KCLKB, CLK_6MB, CLK_1MB,
        input  nZ80NMI, nSDZ80R, nSDZ80W, nSDZ80CLR, nSDROM, nSDMRD, nSDMWR,
        input  SDRD0, SDRD1, n2610CS, n2610RD, n2610WR, nZRAMCS
    );

    modport slave (
        input  SDA_H, SDA_L, nSDRD, nSDWR, nMREQ, nIORQ, nSDW,
        output CLK_12M, CLK_68KCLK, CLK_68KCLKB, CLK_6MB, CLK_1MB,
        output nZ80NMI, nSDZ80R, nSDZ80W, nSDZ80CLR, nSDROM, nSDMRD, nSDMWR,
        output SDRD0, SDRD1, n2610CS, n2610RD, n2610WR, nZRAMCS
    );
endinterface

`default_nettype wire

// File: rtl/neo_d0_sys.sv
// ============================================================================
// neo_d0_sys : NEO-D0 clock divider, Z80 memory/IO decoder and NMI controller
// Rev 1.0
// ============================================================================
`default_nettype none

module neo_d0_sys (
    input  logic        CLK_24M,
    input  logic        nRESET,
    neo_d0_sys_if.slave bus
);

    localparam logic [2:0] c_port_latch = 3'd0;  // 00-03
    localparam logic [2:0] c_port_ym    = 3'd1;  // 04-07
    localparam logic [2:0] c_port_bank0 = 3'd2;  // 08-0B
    localparam logic [2:0] c_port_bank1 = 3'd3;  // 0C-0F
    localparam logic [2:0] c_port_nmids = 3'd6;  // 18-1B
    localparam logic [4:0] c_ram_page   = 5'b11111;

    // Bit positions in the synchronizer vector
    localparam int c_ev_sdw  = 0;
    localparam int c_ev_lrd  = 1;
    localparam int c_ev_nen  = 2;
    localparam int c_ev_ndis = 3;
    localparam int c_ev_n    = 4;

    // ------------------------------------------------------------------------
    // Clock divider
    // ------------------------------------------------------------------------
    logic [3:0] div_q;
    logic [3:0] div_d;

    assign div_d = div_q + 4'd1;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            div_q <= 4'd0;
        end else begin
            div_q <= div_d;
        end
    end

    assign bus.CLK_12M     = div_q[0];
    assign bus.CLK_68KCLK  = div_q[0];
    assign bus.CLK_68KCLKB = ~div_q[0];
    assign bus.CLK_6MB     = ~div_q[1];
    assign bus.CLK_1MB     = ~div_q[3];

    // ------------------------------------------------------------------------
    // Memory decode
    // ------------------------------------------------------------------------
    logic w_mem;
    logic w_ram_page;

    assign w_mem      = ~bus.nMREQ;
    assign w_ram_page = (bus.SDA_H == c_ram_page);

    assign bus.nSDMRD  = bus.nMREQ | bus.nSDRD;
    assign bus.nSDMWR  = bus.nMREQ | bus.nSDWR;
    assign bus.nZRAMCS = ~(w_mem & w_ram_page);
    assign bus.nSDROM  = ~(w_mem & ~w_ram_page);

    // ------------------------------------------------------------------------
    // IO decode
    // ------------------------------------------------------------------------
    logic w_rd;
    logic w_wr;
    logic w_sel_latch;
    logic w_sel_ym;
    logic w_sel_bank0;
    logic w_sel_bank1;
    logic w_sel_nmids;

    assign w_rd = ~bus.nSDRD;
    assign w_wr = ~bus.nSDWR;

    always_comb begin
        w_sel_latch = 1'b0;
        w_sel_ym    = 1'b0;
        w_sel_bank0 = 1'b0;
        w_sel_bank1 = 1'b0;
        w_sel_nmids = 1'b0;
        if (!bus.nIORQ) begin
            case (bus.SDA_L)
                c_port_latch: w_sel_latch = 1'b1;
                c_port_ym:    w_sel_ym    = 1'b1;
                c_port_bank0: w_sel_bank0 = 1'b1;
                c_port_bank1: w_sel_bank1 = 1'b1;
                c_port_nmids: w_sel_nmids = 1'b1;
                default:      ;
            endcase
        end
    end

    assign bus.nSDZ80R   = ~(w_sel_latch & w_rd);
    assign bus.nSDZ80CLR = ~(w_sel_latch & w_wr);
    assign bus.n2610CS   = ~w_sel_ym;
    assign bus.n2610RD   = ~(w_sel_ym & w_rd);
    assign bus.n2610WR   = ~(w_sel_ym & w_wr);
    assign bus.SDRD0     = w_sel_bank0 & w_rd;
    assign bus.SDRD1     = w_sel_bank1 & w_rd;
    assign bus.nSDZ80W   = ~(w_sel_bank1 & w_wr);

    // ------------------------------------------------------------------------
    // NMI logic: asynchronous strobes are synchronised, then the falling edge
    // of the active-high condition marks the end of the access.
    // ------------------------------------------------------------------------
    logic [c_ev_n-1:0] w_ev_raw;
    logic [c_ev_n-1:0] sync1_q;
    logic [c_ev_n-1:0] sync2_q;
    logic [c_ev_n-1:0] sync3_q;
    logic [c_ev_n-1:0] w_ev_end;

    assign w_ev_raw[c_ev_sdw]  = ~bus.nSDW;
    assign w_ev_raw[c_ev_lrd]  = w_sel_latch & w_rd;
    assign w_ev_raw[c_ev_nen]  = w_sel_bank0 & w_wr;
    assign w_ev_raw[c_ev_ndis] = w_sel_nmids & w_wr;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= w_ev_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign w_ev_end = sync3_q & ~sync2_q;

    logic nmi_en_q;
    logic nmi_en_d;
    logic pending_q;
    logic pending_d;
    logic nmi_n_q;

    always_comb begin
        nmi_en_d = nmi_en_q;
        if (w_ev_end[c_ev_nen]) begin
            nmi_en_d = 1'b1;
        end else if (sync2_q[c_ev_ndis]) begin
            nmi_en_d = 1'b0;
        end
    end

    // A new sound command must never be lost to a simultaneous latch read.
    always_comb begin
        pending_d = pending_q;
        if (w_ev_end[c_ev_sdw]) begin
            pending_d = 1'b1;
        end else if (w_ev_end[c_ev_lrd]) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            nmi_en_q  <= 1'b0;
            pending_q <= 1'b0;
            nmi_n_q   <= 1'b1;
        end else begin
            nmi_en_q  <= nmi_en_d;
            pending_q <= pending_d;
            nmi_n_q   <= ~(nmi_en_q & pending_q);
        end
    end

    assign bus.nZ80NMI = nmi_n_q;

endmodule

`default_nettype wire

// File: tb/tb_neo_d0_sys.sv
// ============================================================================
// tb_neo_d0_sys : table-driven decode checks plus clock and NMI sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_neo_d0_sys;

    logic clk;
    logic rst_n;

    neo_d0_sys_if bus ();

    neo_d0_sys u_dut (
        .CLK_24M (clk),
        .nRESET  (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] sb[$];

    // {nSDMRD,nSDMWR,nSDROM,nZRAMCS,nSDZ80R,nSDZ80CLR,nSDZ80W,SDRD0,SDRD1,n2610CS,n2610RD,n2610WR}
    logic [11:0] dec_act;
    assign dec_act = {bus.nSDMRD, bus.nSDMWR, bus.nSDROM, bus.nZRAMCS,
                      bus.nSDZ80R, bus.nSDZ80CLR, bus.nSDZ80W, bus.SDRD0, bus.SDRD1,
                      bus.n2610CS, bus.n2610RD, bus.n2610WR};

    // {CLK_12M, CLK_68KCLK, CLK_68KCLKB, CLK_6MB, CLK_1MB}
    logic [4:0] clk_act;
    assign clk_act = {bus.CLK_12M, bus.CLK_68KCLK, bus.CLK_68KCLKB, bus.CLK_6MB, bus.CLK_1MB};

    typedef struct packed {
        logic        nmreq;
        logic        niorq;
        logic        nrd;
        logic        nwr;
        logic [4:0]  h;
        logic [2:0]  l;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [11:0] act);
        logic [11:0] exp;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected value queued, got %h", name, act);
        end else begin
            exp = sb.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", name, act, exp);
            end
        end
    endtask

    task automatic idle_bus();
        bus.nMREQ = 1'b1;
        bus.nIORQ = 1'b1;
        bus.nSDRD = 1'b1;
        bus.nSDWR = 1'b1;
        bus.nSDW  = 1'b1;
        bus.SDA_H = 5'd0;
        bus.SDA_L = 3'd0;
    endtask

    task automatic io_access(input logic [2:0] port, input bit is_write);
        @(negedge clk);
        bus.nIORQ = 1'b0;
        bus.SDA_L = port;
        if (is_write) bus.nSDWR = 1'b0;
        else          bus.nSDRD = 1'b0;
        repeat (3) @(negedge clk);
        bus.nIORQ = 1'b1;
        bus.nSDWR = 1'b1;
        bus.nSDRD = 1'b1;
    endtask

    task automatic sdw_pulse();
        @(negedge clk);
        bus.nSDW = 1'b0;
        repeat (3) @(negedge clk);
        bus.nSDW = 1'b1;
    endtask

    task automatic nmi_within(input string name, input logic exp, input int budget);
        bit seen = 1'b0;
        sb.push_back({11'd0, exp});
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.nZ80NMI === exp) seen = 1'b1;
        end
        chk(name, {11'd0, bus.nZ80NMI});
    endtask

    task automatic nmi_stays(input string name, input logic exp, input int cycles);
        bit   bad = 1'b0;
        logic obs;
        sb.push_back({11'd0, exp});
        obs = bus.nZ80NMI;
        if (obs !== exp) bad = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!bad) begin
                obs = bus.nZ80NMI;
                if (obs !== exp) bad = 1'b1;
            end
        end
        chk(name, {11'd0, obs});
    endtask

    logic [3:0] div_m;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h1F, 3'd0, 12'b0110_1110_0111}; // RAM read
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h08, 3'd0, 12'b0101_1110_0111}; // ROM read
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'h1F, 3'd0, 12'b1010_1110_0111}; // RAM write
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 5'h1F, 3'd0, 12'b1111_1110_0111}; // no request
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 3'd1, 12'b1111_1110_0010}; // YM write
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 3'd1, 12'b1111_1110_0001}; // YM read
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 3'd0, 12'b1111_0110_0111}; // latch read
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 3'd0, 12'b1111_1010_0111}; // latch clear
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 3'd2, 12'b1111_1111_0111}; // bank0 read
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 3'd3, 12'b1111_1110_1111}; // bank1 read
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 3'd3, 12'b1111_1100_0111}; // reply write
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 3'd5, 12'b1111_1110_0111}; // unused port
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'h08, 3'd3, 12'b0101_1110_0111}; // mem cycle, IO idle
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 3'd2, 12'b1111_1110_0111}; // NMI enable write

        idle_bus();
        rst_n = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        sb.push_back({7'd0, 5'b00111});
        chk("reset_clocks", {7'd0, clk_act});
        sb.push_back(12'd1);
        chk("reset_nmi", {11'd0, bus.nZ80NMI});
        sb.push_back(12'b1111_1110_0111);
        chk("reset_decode", dec_act);

        // Clock division against a reference counter
        rst_n = 1'b1;
        div_m = 4'd0;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            div_m = div_m + 4'd1;
            sb.push_back({7'd0, div_m[0], div_m[0], ~div_m[0], ~div_m[1], ~div_m[3]});
            @(negedge clk);
            chk($sformatf("clkdiv_%0d", i), {7'd0, clk_act});
        end

        // Combinational decode table
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bus.nMREQ = tbl[i].nmreq;
            bus.nIORQ = tbl[i].niorq;
            bus.nSDRD = tbl[i].nrd;
            bus.nSDWR = tbl[i].nwr;
            bus.SDA_H = tbl[i].h;
            bus.SDA_L = tbl[i].l;
            sb.push_back(tbl[i].exp);
            #1;
            chk($sformatf("decode_%0d", i), dec_act);
        end
        idle_bus();

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // NMI flow
        io_access(3'd2, 1'b1);
        repeat (4) @(negedge clk);
        sdw_pulse();
        nmi_within("nmi_assert_4cyc", 1'b0, 4);
        io_access(3'd0, 1'b0);
        nmi_within("nmi_ack_by_latch_read", 1'b1, 6);
        io_access(3'd6, 1'b1);
        repeat (4) @(negedge clk);
        sdw_pulse();
        nmi_stays("nmi_disabled_hold", 1'b1, 8);
        io_access(3'd2, 1'b1);
        nmi_within("nmi_late_enable", 1'b0, 6);

        // Reset mid-NMI
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.push_back(12'd1);
        chk("reset_mid_nmi", {11'd0, bus.nZ80NMI});
        sb.push_back({7'd0, 5'b00111});
        chk("reset_mid_clocks", {7'd0, clk_act});
        @(negedge clk);
        rst_n = 1'b1;
        sdw_pulse();
        nmi_stays("nmi_no_enable_after_reset", 1'b1, 8);

        // Simultaneous set and clear of PENDING: set must win
        @(negedge clk);
        bus.nIORQ = 1'b0;
        bus.SDA_L = 3'd0;
        bus.nSDRD = 1'b0;
        bus.nSDW  = 1'b0;
        repeat (3) @(negedge clk);
        bus.nIORQ = 1'b1;
        bus.nSDRD = 1'b1;
        bus.nSDW  = 1'b1;
        nmi_stays("set_clear_no_enable", 1'b1, 6);
        io_access(3'd2, 1'b1);
        nmi_within("set_wins_over_clear", 1'b0, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
